// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the traffic phase scheduler: lamp codes,
// direction indices, controller states and small arbitration helpers.
package traffic_pkg;

    // Lamp drive codes; 2'b11 is never produced.
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Direction indices, matching the bit order of req/grant.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [4:0] PHASE_MAX = 5'd31;

    typedef enum logic [2:0] {
        ST_FLASH     = 3'd0,
        ST_ALLRED    = 3'd1,
        ST_GREEN     = 3'd2,
        ST_YELLOW    = 3'd3,
        ST_PRE_GREEN = 3'd4
    } state_e;

    // One-hot decode of a direction index.
    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

    // Round-robin pick: search starts one past the last served direction
    // and wraps; returns last unchanged when nothing is requesting.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/request inputs and lamp/status outputs of the intersection
// controller. The slave side is the scheduler, the master side is whatever
// drives the sensors and observes the lamps.
interface traffic_phase_scheduler_if;

    logic [3:0] req;
    logic       preempt;
    logic [1:0] preempt_dir;
    logic [1:0] north;
    logic [1:0] east;
    logic [1:0] south;
    logic [1:0] west;
    logic [3:0] grant;
    logic [4:0] phase_sec;

    modport master (
        output req, preempt, preempt_dir,
        input  north, east, south, west, grant, phase_sec
    );

    modport slave (
        input  req, preempt, preempt_dir,
        output north, east, south, west, grant, phase_sec
    );

endinterface

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// One-second prescaler. Counts clk cycles and pulses tick on the last cycle
// of each period; clr restarts the period so every phase begins aligned.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_TC);

    // Prescaler: wraps on terminal count, restarts on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase scheduler with round-robin service and
// emergency preemption. Lamp and grant outputs are registered from the
// next-state decode so they change on the edge that enters a state.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_FLASH     | all lamps yellow for one tick after reset
// ST_ALLRED    | all red; decides on each tick (preempt first, then req)
// ST_GREEN     | r_dir green; re-arms if it is the sole requester
// ST_YELLOW    | r_dir yellow for YELLOW_SEC ticks, then all red
// ST_PRE_GREEN | r_dir green held for an emergency vehicle until preempt drops
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int GREEN_SEC  = 5,
    parameter int YELLOW_SEC = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_phase_scheduler_if.slave    bus
);

    localparam logic [4:0] GREEN_LAST  = 5'(GREEN_SEC - 1);
    localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_SEC - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_dir;
    logic [1:0] w_dir_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [4:0] r_phase;
    logic [7:0] r_lamps;
    logic [7:0] w_lamps_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic       w_tick;
    logic       w_rearm;
    logic       w_trans;
    logic [3:0] w_others;
    logic [1:0] w_rr_win;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_trans),
        .tick  (w_tick)
    );

    assign w_others = bus.req & ~dir_onehot(r_dir);
    assign w_rr_win = rr_pick(bus.req, r_last);

    // Next-state decode; a re-armed green counts as a transition so the
    // prescaler and phase counter restart with it.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_last_nxt  = r_last;
        w_rearm     = 1'b0;
        unique case (r_state)
            ST_FLASH: begin
                if (w_tick) begin
                    w_state_nxt = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (w_tick) begin
                    if (bus.preempt) begin
                        w_state_nxt = ST_PRE_GREEN;
                        w_dir_nxt   = bus.preempt_dir;
                    end else if (|bus.req) begin
                        w_state_nxt = ST_GREEN;
                        w_dir_nxt   = w_rr_win;
                        w_last_nxt  = w_rr_win;
                    end
                end
            end
            ST_GREEN: begin
                if (bus.preempt) begin
                    // Same direction keeps its green without a lamp change.
                    w_state_nxt = (bus.preempt_dir == r_dir) ? ST_PRE_GREEN : ST_YELLOW;
                end else if (w_tick && (r_phase == GREEN_LAST)) begin
                    if (bus.req[r_dir] && (w_others == 4'b0000)) begin
                        w_rearm = 1'b1;
                    end else begin
                        w_state_nxt = ST_YELLOW;
                    end
                end
            end
            ST_YELLOW: begin
                if (w_tick && (r_phase == YELLOW_LAST)) begin
                    w_state_nxt = ST_ALLRED;
                end
            end
            ST_PRE_GREEN: begin
                if (!bus.preempt) begin
                    w_state_nxt = ST_YELLOW;
                    w_last_nxt  = r_dir;
                end
            end
            default: begin
                w_state_nxt = ST_FLASH;
                w_dir_nxt   = DIR_N;
            end
        endcase
    end

    assign w_trans = (w_state_nxt != r_state) || w_rearm;

    // Lamp/grant image of the state being entered; at most one green.
    always_comb begin
        w_lamps_nxt = {4{LAMP_RED}};
        w_grant_nxt = 4'b0000;
        unique case (w_state_nxt)
            ST_FLASH: begin
                w_lamps_nxt = {4{LAMP_YELLOW}};
            end
            ST_GREEN, ST_PRE_GREEN: begin
                w_lamps_nxt[{w_dir_nxt, 1'b0} +: 2] = LAMP_GREEN;
                w_grant_nxt = dir_onehot(w_dir_nxt);
            end
            ST_YELLOW: begin
                w_lamps_nxt[{w_dir_nxt, 1'b0} +: 2] = LAMP_YELLOW;
            end
            default: begin
                w_lamps_nxt = {4{LAMP_RED}};
            end
        endcase
    end

    // State, direction, arbitration pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FLASH;
            r_dir   <= DIR_N;
            r_last  <= DIR_W;
            r_lamps <= {4{LAMP_YELLOW}};
            r_grant <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_last  <= w_last_nxt;
            r_lamps <= w_lamps_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Ticks spent in the current state, saturating, cleared on any transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (w_trans) begin
            r_phase <= '0;
        end else if (w_tick && (r_phase != PHASE_MAX)) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign bus.north     = r_lamps[1:0];
    assign bus.east      = r_lamps[3:2];
    assign bus.south     = r_lamps[5:4];
    assign bus.west      = r_lamps[7:6];
    assign bus.grant     = r_grant;
    assign bus.phase_sec = r_phase;

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick.
REQ-002 Parameter GREEN_SEC, default 5, green duration in ticks, legal range 1..31.
REQ-003 Parameter YELLOW_SEC, default 1, yellow duration in ticks, legal range 1..31.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  level vehicle-waiting sensors; bit0=N, bit1=E, bit2=S, bit3=W.
REQ-007 preempt  input  1  level emergency-vehicle request.
REQ-008 preempt_dir  input  2  direction to preempt to: 0=N, 1=E, 2=S, 3=W.
REQ-009 north, east, south, west  output  2 each  lamp code: 00=red, 01=yellow, 10=green; 11 is never driven.
REQ-010 grant  output  4  one-hot green direction (same bit order as req); 0 when no direction is green.
REQ-011 phase_sec  output  5  ticks elapsed in the current state; saturates at 31.

Function
REQ-012 States: FLASH, ALLRED, GREEN, YELLOW, PRE_GREEN.
REQ-013 A tick pulse is asserted when the internal prescaler equals TICK_DIV-1; on every state transition the prescaler and phase_sec both clear to 0.
- Result: each state lasts exactly N*TICK_DIV cycles.
REQ-014 FLASH: all four lamps yellow, grant=0; after 1 tick -> ALLRED.
REQ-015 ALLRED: all lamps red, grant=0; minimum dwell 1 tick.
- At end of dwell, preempt=1 -> PRE_GREEN(preempt_dir).
- Otherwise, any req bit set -> GREEN(round-robin winner).
- Otherwise remain in ALLRED; re-evaluate on every tick.
REQ-016 Round-robin: search starts at last_served+1 mod 4 and wraps; the first direction with req set wins; last_served updates on entry to GREEN.
REQ-017 GREEN(d): lamp d green, all other lamps red, grant one-hot d.
- After GREEN_SEC ticks, if no other req bit is set and req[d]=1, the green re-arms (phase_sec clears).
- Otherwise -> YELLOW(d).
REQ-018 YELLOW(d): lamp d yellow, other lamps red, grant=0; after YELLOW_SEC ticks -> ALLRED.
REQ-019 preempt=1 while in GREEN(d):
- d==preempt_dir: convert to PRE_GREEN(d) on the next clock without clearing lamps.
- d!=preempt_dir: go to YELLOW(d) on the next clock, regardless of phase_sec.
REQ-020 preempt=1 during YELLOW or ALLRED: the current timing completes unchanged; ALLRED then exits to PRE_GREEN.
REQ-021 PRE_GREEN(p): lamp p green, grant one-hot p.
- Held while preempt=1; a preempt_dir change is ignored until exit.
- On preempt=0, the next clock -> YELLOW(p), and last_served is set to p.
REQ-022 Simultaneous preempt and req at an ALLRED decision point: preempt wins.
REQ-023 At no time shall two lamps show green, and grant shall never have more than one bit set.
REQ-024 Outputs are registered: lamp and grant changes appear on the clock edge that enters the new state.

Reset
REQ-025 While rst_n=0: state=FLASH, all lamps=01, grant=0, phase_sec=0, prescaler=0, last_served=3 (W), so the first arbitration starts at N.
REQ-026 Reset asserted mid-phase, including PRE_GREEN, aborts immediately with no yellow; FLASH restarts after release.

Structure
REQ-027 Shared package traffic_pkg holds:
- lamp codes RED/YELLOW/GREEN;
- direction indices N/E/S/W;
- the state enumeration.
REQ-028 The prescaler is a separate sub-module, tick_gen (inputs clk, rst_n, clr; output tick); all other logic stays in this module.

Verification (TICK_DIV=4, GREEN_SEC=3, YELLOW_SEC=1)
REQ-029 Reset release with req=0: 4 cycles all-yellow, then all-red held indefinitely, grant=0.
REQ-030 req=4'b1111 held: green order N,E,S,W,N; each green lasts 12 cycles, followed by 4 yellow and 4 all-red cycles.
REQ-031 Only req[1]=1 held: E green re-arms every 12 cycles; phase_sec wraps 0..2 and E never shows yellow.
REQ-032 During N green at phase_sec=1, preempt=1 with preempt_dir=2: N yellow next clock for 4 cycles, all-red for 4 cycles, then S green until preempt=0, then S yellow, then round-robin resumes from W.
REQ-033 rst_n pulsed low during E green: all lamps yellow asynchronously, grant=0 with no clock edge; after release, the FLASH/ALLRED sequence of REQ-029 follows.
REQ-034 Whole-run assertion: there is never more than one green lamp, and grant always equals the one-hot decode of the green lamp.
